vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: word address width toward the VRAM QSPI SRAM controller.
REQ-002 Parameter DATA_WIDTH, default 16: data word width.
REQ-003 Parameter MAX_DISP_RUN, default 4: consecutive display grants allowed while a CPU request waits.
REQ-004 Parameter TIMEOUT_CYCLES, default 255: WAIT cycles before a transaction is abandoned.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 disp_req  in  1  display refresh read request, level, held until disp_ack.
REQ-008 disp_addr  in  ADDR_WIDTH  display read address, stable while disp_req is high.
REQ-009 disp_ack  out  1  one-cycle pulse completing a display transaction.
REQ-010 disp_rdata  out  DATA_WIDTH  read data, valid in the disp_ack cycle.
REQ-011 cpu_req  in  1  CPU request, level, held until cpu_ack.
REQ-012 cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-013 cpu_addr  in  ADDR_WIDTH  CPU address.
REQ-014 cpu_wdata  in  DATA_WIDTH  CPU write data.
REQ-015 cpu_ack  out  1  one-cycle pulse completing a CPU transaction.
REQ-016 cpu_rdata  out  DATA_WIDTH  read data, valid in the cpu_ack cycle.
REQ-017 err  out  1  pulse coincident with an ack whose transaction timed out.
REQ-018 sram_start  out  1  one-cycle command strobe to the SRAM controller.
REQ-019 sram_we  out  1  command direction, 1 = write.
REQ-020 sram_addr  out  ADDR_WIDTH  command address.
REQ-021 sram_wdata  out  DATA_WIDTH  command write data.
REQ-022 sram_done  in  1  one-cycle completion from the controller, never earlier than the cycle after sram_start.
REQ-023 sram_rdata  in  DATA_WIDTH  read data, valid with sram_done.

Function
REQ-024 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-025 IDLE: with any request high, latch the winner, its address, data and direction into command registers, then go to ISSUE; otherwise stay in IDLE.
REQ-026 Arbitration, fixed priority: the display wins unless cpu_req is high and run_cnt == MAX_DISP_RUN; in that case the CPU wins.
REQ-027 Simultaneous requests with run_cnt < MAX_DISP_RUN grant the display.
REQ-028 run_cnt: increments, saturating at MAX_DISP_RUN, on each display grant made while cpu_req is high; clears on a CPU grant or on any IDLE cycle with cpu_req low.
REQ-029 ISSUE lasts exactly one cycle: sram_start=1 and the command registers drive sram_we/addr/wdata; next state is WAIT.
REQ-030 sram_we/addr/wdata hold their values from ISSUE through the end of WAIT.
REQ-031 WAIT: on sram_done, capture sram_rdata (reads only) and go to RESP.
REQ-032 WAIT timeout: a cycle counter counts from 0; reaching TIMEOUT_CYCLES without sram_done sets the timeout flag, leaves the captured data at 0 and goes to RESP.
REQ-033 RESP lasts one cycle: pulse the granted requester's ack, pulse err if the timeout flag is set, then return to IDLE.
REQ-034 Minimum latency, winner sampled in IDLE (cycle 0) to ack: 3 cycles plus the sram_done delay after sram_start.
REQ-035 The ungranted requester gets no ack. Its request stays pending and is arbitrated in the next IDLE.
REQ-036 A requester that drops req after its grant still receives its ack. A request dropped before its grant is ignored.
REQ-037 cpu_rdata is 0 after a CPU write. disp_rdata and cpu_rdata hold their last values outside ack cycles.
REQ-038 sram_done outside WAIT is ignored.

Reset
REQ-039 On reset_n low, immediately and regardless of state: state=IDLE; run_cnt, timeout counter and flag cleared; sram_start, disp_ack, cpu_ack and err = 0; sram_we, sram_addr, sram_wdata, disp_rdata and cpu_rdata = 0.
REQ-040 A transaction cut by reset is dropped without an ack. After release the first rising edge is evaluated as IDLE.

Structure
REQ-041 Package vram_arb_pkg holds the state encoding (2 bits) and the grant encoding (GRANT_DISP, GRANT_CPU).
REQ-042 The design is a single module with no sub-modules; the arbitration decision is one combinational function inside it.

Verification
REQ-043 Display only, disp_addr=0x0010, sram_done 4 cycles after start -> sram_start with we=0 and addr=0x0010; disp_ack 2 cycles after done with disp_rdata equal to sram_rdata.
REQ-044 disp_req and cpu_req held high continuously, MAX_DISP_RUN=4 -> grant sequence D,D,D,D,C,D,D,D,D,C.
REQ-045 CPU write, addr=0x4000, wdata=0xBEEF -> sram_we=1, sram_addr=0x4000, sram_wdata=0xBEEF; cpu_ack pulses with cpu_rdata=0.
REQ-046 sram_done never asserted -> after 255 WAIT cycles the granted ack and err pulse together, rdata=0, FSM back in IDLE.
REQ-047 reset_n pulled low in WAIT -> all outputs 0 asynchronously, no ack; a new disp_req after release is served normally.
REQ-048 disp_req dropped in the cycle after its grant -> disp_ack still pulses once; stray sram_done pulses in IDLE produce no ack.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared encodings for the VRAM arbiter.
//   state_t : transaction FSM states (2-bit encoding)
//   grant_t : which requester owns the current transaction
package vram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_DISP = 1'b0,
    GRANT_CPU  = 1'b1
  } grant_t;

endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter: arbitrates display refresh reads and CPU reads/writes onto a
// single QSPI SRAM controller command port, one transaction at a time.
//
// Ports
//   clk, reset_n                    clock, asynchronous active-low reset
//   disp_req/disp_addr              display read request (level, held to ack)
//   disp_ack/disp_rdata             display completion pulse and read data
//   cpu_req/cpu_we/cpu_addr/
//   cpu_wdata                       CPU request (level, held to ack)
//   cpu_ack/cpu_rdata               CPU completion pulse and read data
//   err                             pulses with an ack whose transaction timed out
//   sram_start/sram_we/sram_addr/
//   sram_wdata                      command strobe and command fields
//   sram_done/sram_rdata            controller completion and read data
//
// The display has priority, but after MAX_DISP_RUN consecutive display grants
// made while the CPU was waiting, the CPU takes the next slot.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_DISP_RUN   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic                  disp_ack,
  output logic [DATA_WIDTH-1:0] disp_rdata,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  err,
  output logic                  sram_start,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic                  sram_done,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam int RW = $clog2(MAX_DISP_RUN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_DISP_RUN);
  localparam logic [TW-1:0] TCNT_END = TW'(TIMEOUT_CYCLES - 1);

  state_t                state, state_next;
  grant_t                grant, win;
  logic [RW-1:0]         run_cnt;
  logic [TW-1:0]         tcnt;
  logic                  timeout_flag;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Fixed priority with an anti-starvation override for the CPU.
  function automatic grant_t arbitrate(input logic d_req, input logic c_req,
                                       input logic [RW-1:0] run);
    if (c_req && (!d_req || run == RUN_MAX)) return GRANT_CPU;
    return GRANT_DISP;
  endfunction

  // Command registers drive the SRAM port directly, so the command fields are
  // stable from ISSUE through the whole WAIT phase.
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  assign sram_we    = cmd_we;
  assign sram_addr  = cmd_addr;
  assign sram_wdata = cmd_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    win        = arbitrate(disp_req, cpu_req, run_cnt);
    sram_start = 1'b0;
    disp_ack   = 1'b0;
    cpu_ack    = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE:  if (disp_req || cpu_req) state_next = ISSUE;
      ISSUE: begin
        sram_start = 1'b1;
        state_next = WAIT;
      end
      WAIT:  if (done_q || tcnt == TCNT_END) state_next = RESP;
      RESP: begin
        disp_ack   = (grant == GRANT_DISP);
        cpu_ack    = (grant == GRANT_CPU);
        err        = timeout_flag;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // sram_done/sram_rdata are registered on entry; WAIT acts on the registered
  // copy, which places the ack two cycles after the controller's done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant        <= GRANT_DISP;
      run_cnt      <= '0;
      tcnt         <= '0;
      timeout_flag <= 1'b0;
      done_q       <= 1'b0;
      rdata_q      <= '0;
      cmd_we       <= 1'b0;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      disp_rdata   <= '0;
      cpu_rdata    <= '0;
    end else begin
      done_q  <= sram_done;
      rdata_q <= sram_rdata;
      case (state)
        IDLE: begin
          tcnt         <= '0;
          timeout_flag <= 1'b0;
          if (!cpu_req) run_cnt <= '0;
          if (disp_req || cpu_req) begin
            grant <= win;
            if (win == GRANT_CPU) begin
              run_cnt   <= '0;
              cmd_we    <= cpu_we;
              cmd_addr  <= cpu_addr;
              cmd_wdata <= cpu_wdata;
            end else begin
              // Only display grants that made the CPU wait count toward the run.
              if (cpu_req && run_cnt != RUN_MAX) run_cnt <= run_cnt + RW'(1);
              cmd_we    <= 1'b0;
              cmd_addr  <= disp_addr;
              cmd_wdata <= '0;
            end
          end
        end
        WAIT: begin
          if (done_q) begin
            if (grant == GRANT_DISP) disp_rdata <= rdata_q;
            else                     cpu_rdata  <= cmd_we ? '0 : rdata_q;
          end else if (tcnt == TCNT_END) begin
            timeout_flag <= 1'b1;
            if (grant == GRANT_DISP) disp_rdata <= '0;
            else                     cpu_rdata  <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
